// File: rtl/pair_sum_stage.sv
// pair_sum_stage: sums disjoint or sliding pairs of signed 4-bit samples into a 5-bit registered output
module pair_sum_stage (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  input  logic       in_last,
  input  logic       sliding,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] out_sum,
  output logic       out_odd,
  output logic [7:0] pair_cnt
);
  typedef enum logic {EMPTY, HELD} state_t;
  state_t state_q, state_d;
  logic [3:0] held_q;
  logic mode_q, xfer, pair, emit;
  logic [4:0] sum_d;
  assign in_ready = !out_valid | out_ready;
  always_comb begin
    xfer = in_valid & in_ready;
    pair = xfer & (state_q == HELD);
    emit = pair | (xfer & in_last);
    sum_d = pair ? {held_q[3], held_q} + {in_data[3], in_data} : {in_data[3], in_data};
    state_d = !xfer ? state_q : (in_last | (pair & !mode_q)) ? EMPTY : HELD;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      held_q <= 4'd0;
      mode_q <= 1'b0;
      out_valid <= 1'b0;
      out_sum <= 5'd0;
      out_odd <= 1'b0;
      pair_cnt <= 8'd0;
    end else begin
      state_q <= state_d;
      if (xfer && state_d == HELD) held_q <= in_data;
      if (xfer && state_q == EMPTY) mode_q <= sliding;
      out_valid <= emit | (out_valid & !out_ready);
      if (emit) begin
        out_sum <= sum_d;
        out_odd <= !pair;
      end
      if (pair && pair_cnt != 8'hFF) pair_cnt <= pair_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_pair_sum_stage.sv
// tb_pair_sum_stage: directed vector table plus randomized run against a segment-level reference model
module tb_pair_sum_stage;
  logic clk = 0, rst = 1, in_valid = 0, in_last = 0, sliding = 0, out_ready = 0;
  logic [3:0] in_data = 0;
  logic in_ready, out_valid, out_odd;
  logic [4:0] out_sum;
  logic [7:0] pair_cnt;
  int cmp = 0, bad = 0;

  pair_sum_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .sliding(sliding), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_odd(out_odd), .pair_cnt(pair_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, iv;
    logic [3:0] d;
    logic last, sl, ordy, e_rdy, e_v;
    logic [4:0] e_sum;
    logic e_odd;
    logic [7:0] e_cnt;
  } vec_t;
  vec_t tbl[24];

  // reference model: samples since the last return to "no held sample" form a segment
  int seg[$];
  logic seg_mode, m_v, m_odd;
  logic [4:0] m_sum;
  int m_cnt;

  task automatic chk(input string name, input int act, input int exp);
    cmp++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_emit(input int s, input logic odd);
    m_v = 1;
    m_sum = 5'(s);
    m_odd = odd;
    if (!odd && m_cnt < 255) m_cnt++;
  endtask

  task automatic model_step(input logic r, input logic iv, input logic [3:0] d, input logic last,
                            input logic sl, input logic ordy);
    logic rdy;
    int n;
    rdy = !m_v | ordy;
    if (r) begin
      seg.delete();
      seg_mode = 0; m_v = 0; m_sum = 0; m_odd = 0; m_cnt = 0;
      return;
    end
    if (m_v && ordy) m_v = 0;
    if (!(iv && rdy)) return;
    if (seg.size() == 0) seg_mode = sl;
    seg.push_back(int'($signed(d)));
    n = seg.size();
    if (n >= 2) m_emit(seg[n-2] + seg[n-1], 0);
    else if (last) m_emit(seg[0], 1);
    if (last || (!seg_mode && n == 2)) seg.delete();
  endtask

  task automatic cyc(input logic r, input logic iv, input logic [3:0] d, input logic last,
                     input logic sl, input logic ordy, input string tag);
    rst = r; in_valid = iv; in_data = d; in_last = last; sliding = sl; out_ready = ordy;
    #1;
    if (!r) chk({tag, " in_ready"}, in_ready, !m_v | ordy);
    model_step(r, iv, d, last, sl, ordy);
    @(posedge clk); #1;
    chk({tag, " out_valid"}, out_valid, m_v);
    chk({tag, " out_sum"}, out_sum, m_sum);
    chk({tag, " out_odd"}, out_odd, m_odd);
    chk({tag, " pair_cnt"}, pair_cnt, m_cnt);
  endtask

  initial begin
    //            rst iv d     lst sl ordy rdy v  sum     odd cnt
    tbl[0]  = '{1, 0, 4'h0, 0, 0, 1, 1, 0, 5'h00, 0, 8'd0};
    tbl[1]  = '{0, 1, 4'h3, 0, 0, 1, 1, 0, 5'h00, 0, 8'd0};
    tbl[2]  = '{0, 1, 4'h5, 0, 0, 1, 1, 1, 5'h08, 0, 8'd1};
    tbl[3]  = '{0, 1, 4'h8, 0, 0, 1, 1, 0, 5'h08, 0, 8'd1};
    tbl[4]  = '{0, 1, 4'h8, 1, 0, 1, 1, 1, 5'h10, 0, 8'd2};
    tbl[5]  = '{0, 1, 4'h7, 0, 1, 1, 1, 0, 5'h10, 0, 8'd2};
    tbl[6]  = '{0, 1, 4'h7, 0, 0, 1, 1, 1, 5'h0E, 0, 8'd3};
    tbl[7]  = '{0, 1, 4'hF, 0, 0, 1, 1, 1, 5'h06, 0, 8'd4};
    tbl[8]  = '{0, 1, 4'h2, 1, 0, 1, 1, 1, 5'h01, 0, 8'd5};
    tbl[9]  = '{0, 1, 4'h4, 0, 0, 1, 1, 0, 5'h01, 0, 8'd5};
    tbl[10] = '{0, 1, 4'hD, 0, 1, 1, 1, 1, 5'h01, 0, 8'd6};
    tbl[11] = '{0, 1, 4'h6, 1, 0, 1, 1, 1, 5'h06, 1, 8'd6};
    tbl[12] = '{0, 1, 4'h2, 0, 0, 0, 0, 1, 5'h06, 1, 8'd6};
    tbl[13] = '{0, 1, 4'h2, 0, 0, 1, 1, 0, 5'h06, 1, 8'd6};
    tbl[14] = '{0, 1, 4'h3, 0, 0, 0, 1, 1, 5'h05, 0, 8'd7};
    tbl[15] = '{0, 1, 4'h1, 1, 0, 0, 0, 1, 5'h05, 0, 8'd7};
    tbl[16] = '{0, 1, 4'h1, 1, 0, 1, 1, 1, 5'h01, 1, 8'd7};
    tbl[17] = '{0, 0, 4'h0, 0, 0, 1, 1, 0, 5'h01, 1, 8'd7};
    tbl[18] = '{0, 1, 4'h5, 0, 0, 1, 1, 0, 5'h01, 1, 8'd7};
    tbl[19] = '{1, 0, 4'h0, 0, 0, 1, 1, 0, 5'h00, 0, 8'd0};
    tbl[20] = '{0, 1, 4'h1, 0, 0, 1, 1, 0, 5'h00, 0, 8'd0};
    tbl[21] = '{0, 1, 4'h2, 1, 0, 1, 1, 1, 5'h03, 0, 8'd1};
    tbl[22] = '{0, 1, 4'h8, 1, 0, 0, 0, 1, 5'h03, 0, 8'd1};
    tbl[23] = '{1, 1, 4'h8, 1, 1, 0, 0, 0, 5'h00, 0, 8'd0};
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 24; i++) begin
      rst = tbl[i].rst; in_valid = tbl[i].iv; in_data = tbl[i].d; in_last = tbl[i].last;
      sliding = tbl[i].sl; out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("vec%0d in_ready", i), in_ready, tbl[i].e_rdy);
      @(posedge clk); #1;
      chk($sformatf("vec%0d out_valid", i), out_valid, tbl[i].e_v);
      chk($sformatf("vec%0d out_sum", i), out_sum, tbl[i].e_sum);
      chk($sformatf("vec%0d out_odd", i), out_odd, tbl[i].e_odd);
      chk($sformatf("vec%0d pair_cnt", i), pair_cnt, tbl[i].e_cnt);
    end
    cyc(1, 0, 4'h0, 0, 0, 1, "rst");
    // held sample survives a long idle gap
    cyc(0, 1, 4'h6, 0, 0, 1, "hold");
    repeat (40) cyc(0, 0, 4'h0, 0, 0, 1, "idle");
    cyc(0, 1, 4'h7, 1, 0, 1, "hold");
    chk("hold sum", out_sum, 5'h0D);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 3) == 0,
          1'($urandom), $urandom_range(0, 3) != 0, "rand");
    cyc(1, 0, 4'h0, 0, 0, 1, "rst");
    for (int i = 0; i < 610; i++) cyc(0, 1, 4'h0, i[0], 0, 1, "sat");
    chk("sat pair_cnt", pair_cnt, 255);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
